// File: rtl/ser_arbiter.sv
// rtl/ser_arbiter.sv - round-robin arbiter sharing one serializer among N_REQ requesters
// Optional strict priority for requester 0 when SER_ARB_PRIO0_EN is defined.
module ser_arbiter #(
  parameter int N_REQ    = 4,
  parameter int START_TO = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [16*N_REQ-1:0]      req_data_i,
  input  logic [4*N_REQ-1:0]       req_mod_i,
  input  logic [N_REQ-1:0]         req_val_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         drop_o,
  output logic [15:0]              ser_data_o,
  output logic [3:0]               ser_mod_o,
  output logic                     ser_val_o,
  input  logic                     ser_busy_i,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     active_o,
  output logic                     err_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(START_TO + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, win_idx, cand;
  logic             win_found, accept, illegal, ptr_upd, err_d;
  logic [N_REQ-1:0] win_onehot, drop_d;
  logic [15:0]      win_data;
  logic [3:0]       win_mod;
  logic [TW-1:0]    timer_q, timer_d;

  // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    ptr_upd   = 1'b1;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (req_val_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef SER_ARB_PRIO0_EN
    if (req_val_i[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      ptr_upd   = 1'b0;
    end
`endif
  end

  always_comb begin
    win_data   = '0;
    win_mod    = '0;
    win_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_found && win_idx == IW'(k)) begin
        win_data      = req_data_i[16*k +: 16];
        win_mod       = req_mod_i[4*k +: 4];
        win_onehot[k] = 1'b1;
      end
    end
  end

  assign accept      = (state_q == IDLE) && !ser_busy_i && win_found;
  assign illegal     = (win_mod == 4'd1) || (win_mod == 4'd2);
  assign req_ready_o = (accept && rst_ni) ? win_onehot : '0;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    drop_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) drop_d  = win_onehot;
          else         state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_START;
        timer_d = '0;
      end
      WAIT_START: begin
        if (ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(START_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!ser_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      timer_q    <= '0;
      ser_data_o <= '0;
      ser_mod_o  <= '0;
      grant_id_o <= '0;
      ser_val_o  <= 1'b0;
      active_o   <= 1'b0;
      err_o      <= 1'b0;
      drop_o     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ser_val_o <= (state_d == LAUNCH);
      active_o  <= (state_d != IDLE);
      err_o     <= err_d;
      drop_o    <= drop_d;
      if (accept) begin
        ser_data_o <= win_data;
        ser_mod_o  <= win_mod;
        grant_id_o <= win_idx;
        if (ptr_upd) ptr_q <= win_idx;
      end
    end
  end
endmodule

// File: tb/tb_ser_arbiter.sv
// tb/tb_ser_arbiter.sv - directed self-checking bench for ser_arbiter
module tb_ser_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic [16*N-1:0] req_data = '0;
  logic [4*N-1:0] req_mod  = '0;
  logic [N-1:0]   req_val  = '0;
  logic           ser_busy = 1'b0;
  logic [N-1:0]   req_ready, drop;
  logic [15:0]    ser_data;
  logic [3:0]     ser_mod;
  logic           ser_val, active, err;
  logic [1:0]     grant_id;

  ser_arbiter #(.N_REQ(N), .START_TO(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_data_i(req_data), .req_mod_i(req_mod),
    .req_val_i(req_val), .req_ready_o(req_ready), .drop_o(drop),
    .ser_data_o(ser_data), .ser_mod_o(ser_mod), .ser_val_o(ser_val),
    .ser_busy_i(ser_busy), .grant_id_o(grant_id), .active_o(active), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [19:0] qmem [N][64];
  int qh [N];
  int qt [N];
  logic [N-1:0] hs_pend = '0;

  logic        busy_m = 1'b0;
  logic [15:0] sh = '0, acc = '0;
  int cnt = 0, slen = 0, never_busy = 0;

  int glog_n = 0, slog_n = 0, acc_n = 0, drop_n = 0, err_n = 0, err_cyc = 0;
  logic [1:0]   glog_id [64];
  logic [15:0]  glog_data [64];
  int           glog_cyc [64];
  logic [15:0]  slog_val [64];
  int           slog_len [64];
  int           fall_cyc [64];
  int           acc_cyc [64];
  int           acc_id [64];
  logic [N-1:0] drop_id [16];
  int           drop_cyc [16];

  // Requester sources, serializer model and monitors, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_m  = 1'b0;
      hs_pend = '0;
    end else begin
      for (int k = 0; k < N; k++) if (hs_pend[k]) qh[k]++;
      if (ser_val && glog_n < 64) begin
        glog_id[glog_n] = grant_id; glog_data[glog_n] = ser_data; glog_cyc[glog_n] = cyc; glog_n++;
      end
      if (drop != '0 && drop_n < 16) begin
        drop_id[drop_n] = drop; drop_cyc[drop_n] = cyc; drop_n++;
      end
      if (err) begin err_n++; err_cyc = cyc; end
      if (ser_val && never_busy == 0) begin
        busy_m = 1'b1; sh = ser_data; acc = '0;
        cnt = (ser_mod == 4'd0) ? 16 : int'(ser_mod);
        slen = cnt;
      end else if (busy_m) begin
        acc = {acc[14:0], sh[15]};
        sh  = {sh[14:0], 1'b0};
        cnt--;
        if (cnt == 0) begin
          busy_m = 1'b0;
          if (slog_n < 64) begin
            slog_val[slog_n] = acc; slog_len[slog_n] = slen; fall_cyc[slog_n] = cyc; slog_n++;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (qh[k] < qt[k]) begin
        req_val[k] = 1'b1;
        {req_mod[4*k +: 4], req_data[16*k +: 16]} = qmem[k][qh[k]];
      end else begin
        req_val[k] = 1'b0;
      end
    end
    ser_busy = busy_m;
    #1;
    hs_pend = req_val & req_ready;
    for (int k = 0; k < N; k++) begin
      if (hs_pend[k] && acc_n < 64) begin acc_id[acc_n] = k; acc_cyc[acc_n] = cyc; acc_n++; end
    end
  end

  task automatic enq(input int k, input logic [15:0] d, input logic [3:0] m);
    if (qt[k] < 64) begin qmem[k][qt[k]] = {m, d}; qt[k]++; end
  endtask

  task automatic clear_queues();
    for (int k = 0; k < N; k++) begin qh[k] = 0; qt[k] = 0; end
  endtask

  task automatic clear_logs();
    glog_n = 0; slog_n = 0; acc_n = 0; drop_n = 0; err_n = 0;
  endtask

  function automatic bit q_empty();
    for (int k = 0; k < N; k++) if (qh[k] != qt[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int streak = 0;
    int n = 0;
    while (streak < 3 && n < budget) begin
      @(negedge clk); #3; n++;
      if (q_empty() && !active && !ser_busy) streak++; else streak = 0;
    end
    checks++;
    if (streak < 3) begin
      failures++;
      $display("FAIL %s_idle: idle not reached within %0d cycles", tag, budget);
    end
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0; never_busy = 0;
    clear_queues();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({req_ready, drop, ser_data, ser_mod, ser_val, grant_id, active, err} !== 33'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {req_ready, drop, ser_data, ser_mod, ser_val, grant_id, active, err});
    end
    rst_n = 1'b1;
    sync();
    checks++;
    if ({req_ready, drop, ser_val, active, err} !== 11'd0) begin
      failures++;
      $display("FAIL reset_release: got %h expected 0", {req_ready, drop, ser_val, active, err});
    end
  endtask

  task automatic test_rr_order();
    int exp_id [4] = '{1, 2, 3, 0};
    sync(); clear_logs();
    for (int k = 0; k < N; k++) enq(k, 16'hA5A5 + 16'(k), 4'd0);
    wait_idle(400, "rr");
    checks++;
    if (glog_n != 4) begin failures++; $display("FAIL rr_launch_count: got %0d expected 4", glog_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (glog_id[i] !== 2'(exp_id[i])) begin
        failures++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, glog_id[i], exp_id[i]);
      end
      checks++;
      if (slog_val[i] !== 16'hA5A5 + 16'(exp_id[i]) || slog_len[i] != 16) begin
        failures++;
        $display("FAIL rr_serial%0d: got %h/%0d expected %h/16", i, slog_val[i], slog_len[i], 16'hA5A5 + 16'(exp_id[i]));
      end
    end
  endtask

  task automatic test_drop();
    sync(); clear_logs();
    enq(2, 16'h1234, 4'd1);
    enq(2, 16'h5678, 4'd2);
    wait_idle(100, "drop");
    checks++;
    if (drop_n != 2) begin failures++; $display("FAIL drop_count: got %0d expected 2", drop_n); end
    checks++;
    if (drop_id[0] !== 4'b0100 || drop_id[1] !== 4'b0100) begin
      failures++; $display("FAIL drop_id: got %b,%b expected 0100,0100", drop_id[0], drop_id[1]);
    end
    checks++;
    if (drop_cyc[1] - drop_cyc[0] != 1) begin
      failures++; $display("FAIL drop_b2b: got gap %0d expected 1", drop_cyc[1] - drop_cyc[0]);
    end
    checks++;
    if (glog_n != 0) begin failures++; $display("FAIL drop_no_launch: got %0d launches expected 0", glog_n); end
    sync(); clear_logs();
    for (int k = 0; k < N; k++) enq(k, 16'h0F00 + 16'(k), 4'd0);
    wait_idle(400, "drop_ptr");
    checks++;
    if (glog_id[0] !== 2'd3) begin failures++; $display("FAIL drop_ptr: first grant %0d expected 3", glog_id[0]); end
  endtask

  task automatic test_timeout();
    int n = 0;
    sync(); clear_logs();
    never_busy = 1;
    enq(1, 16'hBEEF, 4'd0);
    while (err_n == 0 && n < 100) begin @(negedge clk); #3; n++; end
    checks++;
    if (err_n == 0) begin failures++; $display("FAIL timeout_err: no err pulse within 100 cycles"); end
    checks++;
    if (glog_n != 1 || glog_data[0] !== 16'hBEEF) begin
      failures++; $display("FAIL timeout_launch: got %0d launches data %h expected 1 beef", glog_n, glog_data[0]);
    end
    checks++;
    if (err_cyc - glog_cyc[0] != TO + 1) begin
      failures++; $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - glog_cyc[0], TO + 1);
    end
    sync();
    never_busy = 0;
    enq(3, 16'h0C0C, 4'd0);
    wait_idle(200, "timeout");
    checks++;
    if (err_n != 1) begin failures++; $display("FAIL timeout_single: got %0d err pulses expected 1", err_n); end
    checks++;
    if (glog_n != 2 || glog_id[1] !== 2'd3 || glog_data[1] !== 16'h0C0C) begin
      failures++; $display("FAIL timeout_recover: got n=%0d id=%0d data=%h expected 2/3/0c0c", glog_n, glog_id[1], glog_data[1]);
    end
  endtask

  task automatic test_mod5();
    sync(); clear_logs();
    enq(1, 16'hF800, 4'd5);
    enq(1, 16'h1111, 4'd0);
    wait_idle(200, "mod5");
    checks++;
    if (slog_val[0] !== 16'h001F || slog_len[0] != 5) begin
      failures++; $display("FAIL mod5_serial: got %h/%0d expected 001f/5", slog_val[0], slog_len[0]);
    end
    checks++;
    if (acc_n != 2 || acc_cyc[1] != fall_cyc[0] + 1) begin
      failures++; $display("FAIL mod5_next_accept: got n=%0d cyc=%0d expected 2/%0d", acc_n, acc_cyc[1], fall_cyc[0] + 1);
    end
    checks++;
    if (slog_val[1] !== 16'h1111) begin failures++; $display("FAIL mod5_second: got %h expected 1111", slog_val[1]); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    sync(); clear_logs();
    enq(2, 16'hC3C3, 4'd0);
    while (glog_n == 0 && n < 50) begin @(negedge clk); #3; n++; end
    repeat (4) @(negedge clk);
    #3;
    checks++;
    if (!(active === 1'b1 && ser_busy === 1'b1 && grant_id === 2'd2)) begin
      failures++; $display("FAIL midrst_pre: got active=%b busy=%b id=%0d expected 1/1/2", active, ser_busy, grant_id);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, drop, ser_data, ser_mod, ser_val, grant_id, active, err} !== 33'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got %h expected 0", {req_ready, drop, ser_data, ser_mod, ser_val, grant_id, active, err});
    end
    clear_queues();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    for (int k = 0; k < N; k++) enq(k, 16'h0100 + 16'(k), 4'd0);
    wait_idle(500, "midrst");
    checks++;
    if (acc_id[0] != 1 || glog_id[0] !== 2'd1) begin
      failures++; $display("FAIL midrst_first_grant: got %0d/%0d expected 1", acc_id[0], glog_id[0]);
    end
    checks++;
    if (drop_n != 0 || err_n != 0) begin failures++; $display("FAIL midrst_no_pulse: got drop=%0d err=%0d expected 0", drop_n, err_n); end
  endtask

  task automatic test_alternate();
`ifdef SER_ARB_PRIO0_EN
    int exp_id [4] = '{0, 0, 0, 0};
`else
    int exp_id [4] = '{3, 0, 3, 0};
`endif
    do_reset();
    sync();
    for (int i = 0; i < 4; i++) begin
      enq(0, 16'h0A00 + 16'(i), 4'd0);
      enq(3, 16'h3A00 + 16'(i), 4'd0);
    end
    wait_idle(800, "alt");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (glog_id[i] !== 2'(exp_id[i])) begin
        failures++; $display("FAIL alt_grant%0d: got %0d expected %0d", i, glog_id[i], exp_id[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_order();
    test_drop();
    test_timeout();
    test_mod5();
    test_reset_mid();
    test_alternate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
